// File: rtl/nn_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// nn_seq_ctrl_if
// Host-side link between the AHB subordinate and the inference sequencer.
//   wr_en_push  : one-cycle push strobe (subordinate -> sequencer)
//   is_weight   : push qualifier, 1 = weight row, 0 = input vector
//   ctrl_reg    : control register, bit0 start, bit1 clear (level-held)
//   handshake   : one-cycle pulse, host has read output_data
//   status_reg  : sequencer status read back by the subordinate
//   err_reg     : sticky error flags read back by the subordinate
// modport master : subordinate side
// modport slave  : sequencer side
// -----------------------------------------------------------------------------
interface nn_seq_ctrl_if;
   logic        wr_en_push;
   logic        is_weight;
   logic [7:0]  ctrl_reg;
   logic        handshake;
   logic [7:0]  status_reg;
   logic [15:0] err_reg;

   modport master (
      output wr_en_push, is_weight, ctrl_reg, handshake,
      input  status_reg, err_reg
   );

   modport slave (
      input  wr_en_push, is_weight, ctrl_reg, handshake,
      output status_reg, err_reg
   );
endinterface

// File: rtl/nn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// nn_seq_ctrl
// Sequencer for the single-layer inference datapath. Loads weight rows and the
// input vector from host pushes, then runs MAC -> bias -> activation and holds
// the result valid until the host handshakes.
//
// Ports
//   clk         : system clock
//   rst         : synchronous, active-high reset
//   host        : nn_seq_ctrl_if.slave (pushes, ctrl_reg, handshake, status/err)
//   weight_we   : write weight row weight_row (same cycle as the push)
//   weight_row  : row index for weight_we
//   input_we    : latch input vector (same cycle as the push)
//   mac_clr     : clear accumulators, first COMPUTE cycle
//   mac_en      : MAC array enable
//   mac_row     : row streamed during COMPUTE
//   bias_en     : add bias to accumulators
//   act_en      : apply activation
//   out_latch   : capture result into output_data
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | accepting pushes, waiting for a start edge
// S_COMPUTE | MAC array enabled for COMPUTE_CYCLES cycles
// S_BIAS    | one cycle of bias add
// S_ACT     | one cycle of activation, result latched
// S_DONE    | out_valid held until host handshake
// -----------------------------------------------------------------------------
module nn_seq_ctrl #(
   parameter int W_ROWS         = 8,
   parameter int COMPUTE_CYCLES = 12,
   parameter int ROW_W          = 3
) (
   input  logic             clk,
   input  logic             rst,
   nn_seq_ctrl_if.slave     host,
   output logic             weight_we,
   output logic [ROW_W-1:0] weight_row,
   output logic             input_we,
   output logic             mac_clr,
   output logic             mac_en,
   output logic [ROW_W-1:0] mac_row,
   output logic             bias_en,
   output logic             act_en,
   output logic             out_latch
);

   localparam int CNT_W = $clog2(W_ROWS + 1);
   localparam int CYC_W = $clog2(COMPUTE_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COMPUTE,
      S_BIAS,
      S_ACT,
      S_DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] weight_cnt;
   logic [CYC_W-1:0] cyc;
   logic [CYC_W-1:0] cyc_nxt;
   logic             input_valid;
   logic             start_prev;
   logic             clear_prev;
   logic [15:0]      err;

   logic start_edge;
   logic clear_edge;
   logic live;
   logic idle;
   logic push_w;
   logic push_i;
   logic weights_full;
   logic start_go;
   logic busy;
   logic out_valid;
   logic unused_ctrl;

   assign start_edge   = host.ctrl_reg[0] & ~start_prev;
   assign clear_edge   = host.ctrl_reg[1] & ~clear_prev;
   // Same-cycle strobes are suppressed while reset or clear is being applied.
   assign live         = ~rst & ~clear_edge;
   assign idle         = (state == S_IDLE);
   assign push_w       = live & host.wr_en_push & host.is_weight;
   assign push_i       = live & host.wr_en_push & ~host.is_weight;
   assign weights_full = (weight_cnt == CNT_W'(W_ROWS));
   // Start is judged on the registered counts, so a push in the same cycle
   // cannot make an otherwise unready start succeed.
   assign start_go     = live & start_edge & idle & weights_full & input_valid;

   assign weight_we    = push_w & idle & ~weights_full;
   assign weight_row   = weight_we ? weight_cnt[ROW_W-1:0] : '0;
   assign input_we     = push_i & idle;

   assign busy         = (state == S_COMPUTE) | (state == S_BIAS) | (state == S_ACT);
   assign out_valid    = (state == S_DONE);
   assign cyc_nxt      = cyc + 1'b1;

   assign host.status_reg = {4'b0000, input_valid, weights_full, busy, out_valid};
   assign host.err_reg    = err;

   assign unused_ctrl  = ^host.ctrl_reg[7:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         weight_cnt  <= '0;
         cyc         <= '0;
         input_valid <= 1'b0;
         start_prev  <= 1'b0;
         clear_prev  <= 1'b0;
         err         <= '0;
         mac_clr     <= 1'b0;
         mac_en      <= 1'b0;
         mac_row     <= '0;
         bias_en     <= 1'b0;
         act_en      <= 1'b0;
         out_latch   <= 1'b0;
      end else begin
         start_prev <= host.ctrl_reg[0];
         clear_prev <= host.ctrl_reg[1];

         if (clear_edge) begin
            state       <= S_IDLE;
            weight_cnt  <= '0;
            cyc         <= '0;
            input_valid <= 1'b0;
            err         <= '0;
            mac_clr     <= 1'b0;
            mac_en      <= 1'b0;
            mac_row     <= '0;
            bias_en     <= 1'b0;
            act_en      <= 1'b0;
            out_latch   <= 1'b0;
         end else begin
            if (weight_we)
               weight_cnt <= weight_cnt + 1'b1;

            if (push_w & idle & weights_full)
               err[0] <= 1'b1;
            if (start_edge & idle & ~(weights_full & input_valid))
               err[1] <= 1'b1;
            if (host.wr_en_push & ~idle)
               err[2] <= 1'b1;
            if (start_edge & ~idle)
               err[3] <= 1'b1;
            if (push_i & idle & input_valid)
               err[8] <= 1'b1;

            // A push landing with a successful start is kept for the next run.
            if (input_we)
               input_valid <= 1'b1;
            else if (start_go)
               input_valid <= 1'b0;

            case (state)
               S_IDLE: begin
                  if (start_go) begin
                     state   <= S_COMPUTE;
                     cyc     <= '0;
                     mac_en  <= 1'b1;
                     mac_clr <= 1'b1;
                     mac_row <= '0;
                  end
               end
               S_COMPUTE: begin
                  mac_clr <= 1'b0;
                  if (cyc == CYC_W'(COMPUTE_CYCLES - 1)) begin
                     state   <= S_BIAS;
                     mac_en  <= 1'b0;
                     mac_row <= '0;
                     bias_en <= 1'b1;
                  end else begin
                     cyc     <= cyc_nxt;
                     // Rows past the last weight keep streaming the last row.
                     mac_row <= (cyc_nxt < CYC_W'(W_ROWS)) ? cyc_nxt[ROW_W-1:0]
                                                           : ROW_W'(W_ROWS - 1);
                  end
               end
               S_BIAS: begin
                  state     <= S_ACT;
                  bias_en   <= 1'b0;
                  act_en    <= 1'b1;
                  out_latch <= 1'b1;
               end
               S_ACT: begin
                  state     <= S_DONE;
                  act_en    <= 1'b0;
                  out_latch <= 1'b0;
               end
               S_DONE: begin
                  if (host.handshake)
                     state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
